gnrl_xchk_sched: RTL



---
 rtl/gnrl_xchk_pkg.sv | 19 +
 rtl/gnrl_rr_pick.sv | 33 +++
 rtl/gnrl_xchk_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gnrl_xchk_pkg.sv
// Shared types and defaults for the time-multiplexed X-check scheduler.
package gnrl_xchk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HALT = 2'd2
    } xchk_state_e;

    localparam int XCHK_NCH_DEF   = 4;
    localparam int XCHK_DW_DEF    = 32;
    localparam int XCHK_CNT_W_DEF = 16;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gnrl_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr_i, wrapping.
module gnrl_rr_pick
    import gnrl_xchk_pkg::*;
#(
    parameter int NCH = XCHK_NCH_DEF
) (
    input  logic [NCH-1:0]             req_i,
    input  logic [clog2_min1(NCH)-1:0] ptr_i,
    output logic [clog2_min1(NCH)-1:0] gnt_idx_o,
    output logic                       gnt_vld_o
);

    localparam int IW = clog2_min1(NCH);

    // Walk offsets from farthest to nearest so the nearest request is the last one kept.
    always_comb begin
        int idx;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        idx       = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (req_i[idx]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/gnrl_xchk_sched.sv
// Shared X/Z monitor: one round-robin sample per cycle, evaluated one cycle later.
// Optional build macro GNRL_XCHK_FATAL_EN stops simulation on the first X/Z hit
// (left out when FPGA_SOURCE is defined).
//
// state | meaning
// IDLE  | not sampling; waiting for i_en
// SCAN  | sampling one valid channel per cycle
// HALT  | stopped after an error; only i_clr leaves
module gnrl_xchk_sched
    import gnrl_xchk_pkg::*;
#(
    parameter int NCH         = XCHK_NCH_DEF,
    parameter int DW          = XCHK_DW_DEF,
    parameter int CNT_W       = XCHK_CNT_W_DEF,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_en,
    input  logic                       i_clr,
    input  logic [NCH-1:0]             i_vld,
    input  logic [NCH*DW-1:0]          i_dat,
    output logic                       o_busy,
    output logic                       o_halt,
    output logic [NCH-1:0]             o_err,
    output logic                       o_first_vld,
    output logic [clog2_min1(NCH)-1:0] o_first_ch,
    output logic [CNT_W-1:0]           o_err_cnt
);

    localparam int IW = clog2_min1(NCH);

    xchk_state_e      state_q;
    logic             busy_q, halt_q;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic             s_vld_q;
    logic [IW-1:0]    s_ch_q;
    logic [DW-1:0]    s_dat_q;
    logic [NCH-1:0]   err_q;
    logic             first_vld_q;
    logic [IW-1:0]    first_ch_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic          gnt_vld;
    logic [IW-1:0] gnt_idx;
    logic          parity;
    logic          err_hit;
    logic          halt_now;
    logic          take;

    gnrl_rr_pick #(.NCH(NCH)) u_pick (
        .req_i     (i_vld),
        .ptr_i     (ptr_q),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // The case-equality against X is a simulation-only check; synthesis folds it to 0.
    assign parity   = ^s_dat_q;
    assign err_hit  = s_vld_q && (parity === 1'bx);
    assign halt_now = err_hit && (HALT_ON_ERR != 0);
    // No new sample on the cycle the FSM leaves SCAN.
    assign take     = (state_q == SCAN) && i_en && !halt_now;
    assign ptr_d    = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + IW'(1);
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Scan-control FSM with registered busy/halt decodes.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_en) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (halt_now) begin
                        state_q <= HALT;
                        busy_q  <= 1'b0;
                        halt_q  <= 1'b1;
                    end else if (!i_en) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                HALT: state_q <= HALT;
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    halt_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the granted channel and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_vld_q <= 1'b0;
            s_ch_q  <= '0;
            s_dat_q <= '0;
            ptr_q   <= '0;
        end else if (i_clr) begin
            s_vld_q <= 1'b0;
        end else if (take && gnt_vld) begin
            s_vld_q <= 1'b1;
            s_ch_q  <= gnt_idx;
            s_dat_q <= i_dat[int'(gnt_idx) * DW +: DW];
            ptr_q   <= ptr_d;
        end else begin
            s_vld_q <= 1'b0;
        end
    end

    // Stage 2: sticky per-channel flags, first failing channel, saturating count; clear wins.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            err_q       <= '0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
            cnt_q       <= '0;
        end else if (err_hit) begin
            err_q[s_ch_q] <= 1'b1;
            cnt_q         <= cnt_d;
            if (!first_vld_q) begin
                first_vld_q <= 1'b1;
                first_ch_q  <= s_ch_q;
            end
        end
    end

`ifdef GNRL_XCHK_FATAL_EN
`ifndef FPGA_SOURCE
    // Stop the run at the exact cycle the flags would latch an X/Z hit.
    always_ff @(posedge clk) begin
        if (!rst && !i_clr && err_hit) begin
            $fatal(1, "gnrl_xchk_sched: X/Z detected on channel %0d", s_ch_q);
        end
    end
`endif
`endif

    assign o_busy      = busy_q;
    assign o_halt      = halt_q;
    assign o_err       = err_q;
    assign o_first_vld = first_vld_q;
    assign o_first_ch  = first_ch_q;
    assign o_err_cnt   = cnt_q;

endmodule
